// File: rtl/arm_defs_pkg.sv
// Shared ARM data-processing definitions: opcode encodings, CPSR flag positions
// and the logical/arithmetic opcode classification used by the ALU.
package arm_defs_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_RSC = 4'b0111;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam int unsigned CPSR_N = 31;
    localparam int unsigned CPSR_Z = 30;
    localparam int unsigned CPSR_C = 29;
    localparam int unsigned CPSR_V = 28;

    // Logical opcodes take C from the shifter/CPSR and never touch V.
    function automatic logic is_logical(input logic [3:0] op);
        logic res;
        case (op)
            OP_AND, OP_EOR, OP_TST, OP_TEQ,
            OP_ORR, OP_MOV, OP_BIC, OP_MVN: res = 1'b1;
            default:                         res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/arm_alu_addsub.sv
// 33-bit adder for ARM arithmetic opcodes: selects operand order, inversion of
// the subtrahend and carry-in, and reports sum, carry-out and signed overflow.
module arm_alu_addsub
    import arm_defs_pkg::*;
(
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [3:0]  op_sel,
    input  logic        carry_flag,
    output logic [31:0] sum,
    output logic        carry,
    output logic        overflow
);

    logic [31:0] add_a_s;
    logic [31:0] add_b_s;
    logic        cin_s;
    logic [32:0] sum33_s;

    // Map opcode onto a + b + cin; subtraction is a + ~b + cin.
    always_comb begin
        add_a_s = op1;
        add_b_s = op2;
        cin_s   = 1'b0;
        case (op_sel)
            OP_SUB, OP_CMP: begin
                add_a_s = op1;
                add_b_s = ~op2;
                cin_s   = 1'b1;
            end
            OP_RSB: begin
                add_a_s = op2;
                add_b_s = ~op1;
                cin_s   = 1'b1;
            end
            OP_ADD, OP_CMN: begin
                add_a_s = op1;
                add_b_s = op2;
                cin_s   = 1'b0;
            end
            OP_ADC: begin
                add_a_s = op1;
                add_b_s = op2;
                cin_s   = carry_flag;
            end
            OP_SBC: begin
                add_a_s = op1;
                add_b_s = ~op2;
                cin_s   = carry_flag;
            end
            OP_RSC: begin
                add_a_s = op2;
                add_b_s = ~op1;
                cin_s   = carry_flag;
            end
            default: begin
                add_a_s = op1;
                add_b_s = op2;
                cin_s   = 1'b0;
            end
        endcase
    end

    assign sum33_s  = {1'b0, add_a_s} + {1'b0, add_b_s} + {32'd0, cin_s};
    assign sum      = sum33_s[31:0];
    assign carry    = sum33_s[32];
    // Overflow: adder inputs share a sign that the result does not.
    assign overflow = (add_a_s[31] == add_b_s[31]) && (sum33_s[31] != add_a_s[31]);

endmodule

// File: rtl/arm_alu.sv
// Registered 32-bit ARM data-processing ALU producing result and next CPSR.
// Optional macro ARM_ALU_SHIFTER_CARRY_EN adds shift_carry as C source for logical ops.
module arm_alu
    import arm_defs_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_op1,
    input  logic [31:0] alu_op2,
    input  logic [3:0]  alu_op_sel,
    input  logic [31:0] cpsr_prev,
`ifdef ARM_ALU_SHIFTER_CARRY_EN
    input  logic        shift_carry,
`endif
    output logic [31:0] alu_out,
    output logic [31:0] cpsr_next
);

    logic [31:0] arith_sum_s;
    logic        arith_carry_s;
    logic        arith_ovf_s;
    logic [31:0] result_s;
    logic        flag_c_s;
    logic        flag_v_s;
    logic        logic_c_s;
    logic [31:0] cpsr_s;
    logic [31:0] alu_out_r;
    logic [31:0] cpsr_next_r;

    arm_alu_addsub u_addsub (
        .op1        (alu_op1),
        .op2        (alu_op2),
        .op_sel     (alu_op_sel),
        .carry_flag (cpsr_prev[CPSR_C]),
        .sum        (arith_sum_s),
        .carry      (arith_carry_s),
        .overflow   (arith_ovf_s)
    );

`ifdef ARM_ALU_SHIFTER_CARRY_EN
    assign logic_c_s = shift_carry;
`else
    assign logic_c_s = cpsr_prev[CPSR_C];
`endif

    // Result select; compare/test opcodes still present their value.
    always_comb begin
        result_s = 32'd0;
        case (alu_op_sel)
            OP_AND, OP_TST: result_s = alu_op1 & alu_op2;
            OP_EOR, OP_TEQ: result_s = alu_op1 ^ alu_op2;
            OP_ORR:         result_s = alu_op1 | alu_op2;
            OP_MOV:         result_s = alu_op2;
            OP_BIC:         result_s = alu_op1 & ~alu_op2;
            OP_MVN:         result_s = ~alu_op2;
            default:        result_s = arith_sum_s;
        endcase
    end

    // C/V come from the adder for arithmetic ops, otherwise are carried over.
    always_comb begin
        flag_c_s = cpsr_prev[CPSR_C];
        flag_v_s = cpsr_prev[CPSR_V];
        if (is_logical(alu_op_sel)) begin
            flag_c_s = logic_c_s;
            flag_v_s = cpsr_prev[CPSR_V];
        end else begin
            flag_c_s = arith_carry_s;
            flag_v_s = arith_ovf_s;
        end
    end

    assign cpsr_s = {result_s[31], (result_s == 32'd0), flag_c_s, flag_v_s, cpsr_prev[27:0]};

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_out_r   <= 32'd0;
            cpsr_next_r <= 32'd0;
        end else begin
            alu_out_r   <= result_s;
            cpsr_next_r <= cpsr_s;
        end
    end

    assign alu_out   = alu_out_r;
    assign cpsr_next = cpsr_next_r;

endmodule

// File: tb/tb_arm_alu.sv
// Scoreboard bench for arm_alu: directed vectors push expectations, a monitor
// pops and compares one registered result per clock.
module tb_arm_alu;

    logic        clk;
    logic        reset;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_op_sel;
    logic [31:0] cpsr_prev;
    logic        shift_carry;
    logic [31:0] alu_out;
    logic [31:0] cpsr_next;

    typedef struct {
        string       name;
        logic [31:0] out;
        logic [31:0] cpsr;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;
    bit   done;

    arm_alu dut (
        .clk        (clk),
        .reset      (reset),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_op_sel (alu_op_sel),
        .cpsr_prev  (cpsr_prev),
`ifdef ARM_ALU_SHIFTER_CARRY_EN
        .shift_carry(shift_carry),
`endif
        .alu_out    (alu_out),
        .cpsr_next  (cpsr_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input string name, input logic rst, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] cp,
                         input logic [31:0] eo, input logic [31:0] ec);
        exp_t e;
        @(negedge clk);
        reset      = rst;
        alu_op_sel = op;
        alu_op1    = a;
        alu_op2    = b;
        cpsr_prev  = cp;
        e.name = name;
        e.out  = eo;
        e.cpsr = ec;
        exp_q.push_back(e);
    endtask

    // Monitor: every edge that follows an issued vector presents its result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (alu_out !== e.out || cpsr_next !== e.cpsr) begin
                    miscompares++;
                    $display("FAIL %s: alu_out=%08h cpsr_next=%08h expected alu_out=%08h cpsr_next=%08h",
                             e.name, alu_out, cpsr_next, e.out, e.cpsr);
                end
            end
        end
    end

    initial begin
        logic [31:0] and_c_cpsr;
        vectors     = 0;
        miscompares = 0;
        done        = 1'b0;
        reset       = 1'b1;
        alu_op1     = 32'd0;
        alu_op2     = 32'd0;
        alu_op_sel  = 4'd0;
        cpsr_prev   = 32'd0;
        shift_carry = 1'b0;

        issue("reset", 1'b1, 4'b0100, 32'h1234, 32'h5678, 32'hF000_00FF, 32'h0, 32'h0);

        issue("AND", 1'b0, 4'b0000, 32'd32, 32'd96, 32'h0, 32'h0000_0020, 32'h0000_0000);
        issue("EOR", 1'b0, 4'b0001, 32'd32, 32'd96, 32'h0, 32'h0000_0040, 32'h0000_0000);
        issue("SUB", 1'b0, 4'b0010, 32'd32, 32'd96, 32'h0, 32'hFFFF_FFC0, 32'h8000_0000);
        issue("RSB", 1'b0, 4'b0011, 32'd32, 32'd96, 32'h0, 32'h0000_0040, 32'h2000_0000);
        issue("ORR", 1'b0, 4'b1100, 32'd32, 32'd96, 32'h0, 32'h0000_0060, 32'h0000_0000);
        issue("ADD", 1'b0, 4'b0100, 32'd32, 32'd96, 32'h0, 32'h0000_0080, 32'h0000_0000);
        issue("BIC", 1'b0, 4'b1110, 32'd32, 32'd96, 32'h0, 32'h0000_0000, 32'h4000_0000);

        issue("ADD_ovf",  1'b0, 4'b0100, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h8000_0000, 32'h9000_0000);
        issue("ADD_wrap", 1'b0, 4'b0100, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0000_0000, 32'h6000_0000);
        issue("SUB_zero", 1'b0, 4'b0010, 32'h0, 32'h0, 32'h0, 32'h0000_0000, 32'h6000_0000);

        issue("ADC_c1", 1'b0, 4'b0101, 32'd5, 32'd3, 32'h2000_0000, 32'd9, 32'h0000_0000);
        issue("SBC_c1", 1'b0, 4'b0110, 32'd5, 32'd3, 32'h2000_0000, 32'd2, 32'h2000_0000);
        issue("SBC_c0", 1'b0, 4'b0110, 32'd5, 32'd3, 32'h0000_0000, 32'd1, 32'h2000_0000);
        issue("RSC_c0", 1'b0, 4'b0111, 32'd3, 32'd5, 32'h0000_0000, 32'd1, 32'h2000_0000);
        issue("CMP_eq", 1'b0, 4'b1010, 32'd7, 32'd7, 32'h0000_0000, 32'd0, 32'h6000_0000);
        issue("CMN",    1'b0, 4'b1011, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'd0, 32'h6000_0000);
        issue("MVN",    1'b0, 4'b1111, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000);
        issue("MOV",    1'b0, 4'b1101, 32'hDEAD, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'h0000_0000);
        issue("TST",    1'b0, 4'b1000, 32'hF0, 32'h0F, 32'h0000_001F, 32'h0, 32'h4000_001F);
        issue("TEQ_v",  1'b0, 4'b1001, 32'hA5, 32'hA5, 32'h1000_0000, 32'h0, 32'h5000_0000);

`ifdef ARM_ALU_SHIFTER_CARRY_EN
        and_c_cpsr = 32'h1000_001F;
`else
        and_c_cpsr = 32'h3000_001F;
`endif
        issue("AND_keep", 1'b0, 4'b0000, 32'hFF, 32'h0F, 32'h3000_001F, 32'h0000_000F, and_c_cpsr);
        issue("reset_mid", 1'b1, 4'b0100, 32'd1, 32'd2, 32'hF000_0000, 32'h0, 32'h0);
        issue("after_rst", 1'b0, 4'b0100, 32'd1, 32'd2, 32'h0, 32'd3, 32'h0);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d results never observed, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
